// File: rtl/tank_pkg.sv
// Shared constants and types for the tank game's maze collision logic.
// Screen geometry, maze ROM addressing and the collision scheduler's enums.
package tank_pkg;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int CELL_SHIFT = 4;
  localparam int MAZE_W     = 40;
  localparam int ADDR_W     = 11;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} probe_dir_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} coll_state_t;
endpackage

// File: rtl/maze_probe_addr.sv
// Combinational probe generator: one pixel beyond an object's bounding box in a given
// direction, converted to a maze ROM cell address, with an off-screen indication.
module maze_probe_addr
  import tank_pkg::*;
(
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [9:0]        s,
  input  probe_dir_t        dir,
  output logic [ADDR_W-1:0] addr,
  output logic              off_screen
);
  logic [10:0] x_s, y_s, d_s, px_s, py_s;

  assign x_s = {1'b0, x};
  assign y_s = {1'b0, y};
  assign d_s = {1'b0, s} + 11'd1;

  // Probe coordinates in 11-bit two's complement; bit 10 set means negative.
  always_comb begin
    px_s = x_s;
    py_s = y_s;
    case (dir)
      DIR_UP:    py_s = y_s - d_s;
      DIR_DOWN:  py_s = y_s + d_s;
      DIR_LEFT:  px_s = x_s - d_s;
      DIR_RIGHT: px_s = x_s + d_s;
      default: begin
        px_s = x_s;
        py_s = y_s;
      end
    endcase
  end

  // Off-screen probes read cell 0 so the ROM access pattern stays fixed.
  always_comb begin
    off_screen = px_s[10] | py_s[10] | (px_s >= 11'(SCREEN_W)) | (py_s >= 11'(SCREEN_H));
    if (off_screen) begin
      addr = '0;
    end else begin
      addr = ADDR_W'(py_s[9:CELL_SHIFT]) * ADDR_W'(MAZE_W) + ADDR_W'(px_s[9:CELL_SHIFT]);
    end
  end
endmodule

// File: rtl/maze_collision_scheduler.sv
// Time-shares the single-port maze ROM across all objects once per frame and publishes
// per-object wall flags atomically when the scan completes.
module maze_collision_scheduler
  import tank_pkg::*;
#(
  parameter int N_OBJ = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [N_OBJ-1:0][9:0] obj_x,
  input  logic [N_OBJ-1:0][9:0] obj_y,
  input  logic [N_OBJ-1:0][9:0] obj_s,
  output logic                  maze_rd,
  output logic [ADDR_W-1:0]     maze_addr,
  input  logic                  maze_q,
  output logic [N_OBJ-1:0]      wall_top,
  output logic [N_OBJ-1:0]      wall_bottom,
  output logic [N_OBJ-1:0]      wall_left,
  output logic [N_OBJ-1:0]      wall_right,
  output logic                  busy,
  output logic                  done
);
  localparam int NP = 4 * N_OBJ;
  localparam int PW = $clog2(NP + 1);
  localparam int SW = $clog2(NP);
  localparam int OW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  coll_state_t state_r, state_nx_s;
  logic [PW-1:0] p_r, p_nx_s;
  logic [N_OBJ-1:0][9:0] snap_x_r, snap_y_r, snap_s_r;
  logic snap_en_s;
  logic [SW-1:0] iss_s, iss_slot_r, cap_slot_r;
  logic [OW-1:0] obj_idx_s;
  logic iss_ovr_r, cap_vld_r, cap_ovr_r;
  logic [9:0] src_x_s, src_y_s, src_s_s;
  logic [ADDR_W-1:0] probe_addr_s, maze_addr_r, addr_nx_s;
  logic off_s, maze_rd_r, rd_nx_s;
  logic [NP-1:0] shadow_r, shadow_nx_s;
  logic [N_OBJ-1:0] top_r, bottom_r, left_r, right_r;
  logic [N_OBJ-1:0] top_nx_s, bottom_nx_s, left_nx_s, right_nx_s;
  logic busy_r, busy_nx_s, done_r, done_nx_s;

  assign obj_idx_s = OW'(p_r[SW-1:0] >> 3'd2);

  // Probe 0 is issued from the live inputs in the same edge the snapshot is taken.
  always_comb begin
    if (state_r == IDLE) begin
      iss_s   = '0;
      src_x_s = obj_x[0];
      src_y_s = obj_y[0];
      src_s_s = obj_s[0];
    end else begin
      iss_s   = p_r[SW-1:0];
      src_x_s = snap_x_r[obj_idx_s];
      src_y_s = snap_y_r[obj_idx_s];
      src_s_s = snap_s_r[obj_idx_s];
    end
  end

  maze_probe_addr u_probe (
    .x          (src_x_s),
    .y          (src_y_s),
    .s          (src_s_s),
    .dir        (probe_dir_t'(iss_s[1:0])),
    .addr       (probe_addr_s),
    .off_screen (off_s)
  );

  // Shadow flags absorb the read returning this cycle; edge override never looks at maze_q.
  always_comb begin
    shadow_nx_s = shadow_r;
    if (cap_vld_r) begin
      if (cap_ovr_r) begin
        shadow_nx_s[cap_slot_r] = 1'b1;
      end else begin
        shadow_nx_s[cap_slot_r] = maze_q;
      end
    end else begin
      shadow_nx_s = shadow_r;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx_s  = state_r;
    p_nx_s      = p_r;
    rd_nx_s     = 1'b0;
    addr_nx_s   = '0;
    busy_nx_s   = busy_r;
    done_nx_s   = 1'b0;
    snap_en_s   = 1'b0;
    top_nx_s    = top_r;
    bottom_nx_s = bottom_r;
    left_nx_s   = left_r;
    right_nx_s  = right_r;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          state_nx_s = SCAN;
          p_nx_s     = PW'(1);
          rd_nx_s    = 1'b1;
          addr_nx_s  = probe_addr_s;
          busy_nx_s  = 1'b1;
          snap_en_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SCAN: begin
        if (p_r == PW'(NP)) begin
          state_nx_s = DRAIN;
        end else begin
          rd_nx_s   = 1'b1;
          addr_nx_s = probe_addr_s;
          p_nx_s    = p_r + PW'(1);
        end
      end
      DRAIN: begin
        state_nx_s = COMMIT;
        done_nx_s  = 1'b1;
        for (int i = 0; i < N_OBJ; i++) begin
          top_nx_s[i]    = shadow_nx_s[4*i];
          bottom_nx_s[i] = shadow_nx_s[4*i+1];
          left_nx_s[i]   = shadow_nx_s[4*i+2];
          right_nx_s[i]  = shadow_nx_s[4*i+3];
        end
      end
      COMMIT: begin
        state_nx_s = IDLE;
        busy_nx_s  = 1'b0;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, read pipeline, shadow and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      p_r         <= '0;
      maze_rd_r   <= 1'b0;
      maze_addr_r <= '0;
      iss_slot_r  <= '0;
      iss_ovr_r   <= 1'b0;
      cap_vld_r   <= 1'b0;
      cap_slot_r  <= '0;
      cap_ovr_r   <= 1'b0;
      shadow_r    <= '0;
      top_r       <= '0;
      bottom_r    <= '0;
      left_r      <= '0;
      right_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      p_r         <= p_nx_s;
      maze_rd_r   <= rd_nx_s;
      maze_addr_r <= addr_nx_s;
      iss_slot_r  <= iss_s;
      iss_ovr_r   <= off_s;
      cap_vld_r   <= maze_rd_r;
      cap_slot_r  <= iss_slot_r;
      cap_ovr_r   <= iss_ovr_r;
      shadow_r    <= shadow_nx_s;
      top_r       <= top_nx_s;
      bottom_r    <= bottom_nx_s;
      left_r      <= left_nx_s;
      right_r     <= right_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
    end
  end

  // Object snapshot taken when a scan is accepted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap_x_r <= '0;
      snap_y_r <= '0;
      snap_s_r <= '0;
    end else if (snap_en_s) begin
      snap_x_r <= obj_x;
      snap_y_r <= obj_y;
      snap_s_r <= obj_s;
    end
  end

  assign maze_rd     = maze_rd_r;
  assign maze_addr   = maze_addr_r;
  assign wall_top    = top_r;
  assign wall_bottom = bottom_r;
  assign wall_left   = left_r;
  assign wall_right  = right_r;
  assign busy        = busy_r;
  assign done        = done_r;
endmodule

// File: tb/tb_maze_collision_scheduler.sv
// Scoreboard bench for maze_collision_scheduler: expected ROM addresses, read cycles and
// wall flags are queued when a scan is launched and checked as the DUT produces them.
module tb_maze_collision_scheduler;
  import tank_pkg::*;
  localparam int N = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_start = 1'b0;
  logic [N-1:0][9:0] obj_x = '0, obj_y = '0, obj_s = '0;
  logic maze_rd, maze_q, busy, done;
  logic [ADDR_W-1:0] maze_addr;
  logic [N-1:0] wall_top, wall_bottom, wall_left, wall_right;

  maze_collision_scheduler #(.N_OBJ(N)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .obj_x(obj_x), .obj_y(obj_y), .obj_s(obj_s),
    .maze_rd(maze_rd), .maze_addr(maze_addr), .maze_q(maze_q),
    .wall_top(wall_top), .wall_bottom(wall_bottom), .wall_left(wall_left), .wall_right(wall_right),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;
  int rom_mode = 0;
  int ox[N], oy[N], os[N];
  int exp_addr_q[$];
  int exp_rel_q[$];
  logic [4*N-1:0] exp_flags_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic bit rom_bit(input int a);
    if (rom_mode == 0) return (a == 245);
    else if (rom_mode == 1) return 1'b0;
    else return 1'b1;
  endfunction

  // Synchronous ROM model: data valid the cycle after the read strobe.
  always @(posedge Clk) maze_q <= (maze_rd === 1'b1) ? rom_bit(int'(maze_addr)) : 1'b0;

  // Scoreboard monitor.
  always @(negedge Clk) begin
    int rel, ea, er;
    logic [4*N-1:0] ef;
    rel = cyc - start_cyc;
    if (maze_rd === 1'b1) begin
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read cyc_rel=%0d addr=%0d required=no read", rel, maze_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        er = exp_rel_q.pop_front();
        if (int'(maze_addr) !== ea) begin
          n_fail++;
          $display("FAIL read_addr cyc_rel=%0d actual=%0d required=%0d", rel, maze_addr, ea);
        end
        n_checks++;
        if (rel !== er) begin
          n_fail++;
          $display("FAIL read_cycle actual=%0d required=%0d", rel, er);
        end
      end
    end
    if (done === 1'b1) begin
      done_count++;
      n_checks++;
      if (exp_flags_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc_rel=%0d", rel);
      end else begin
        ef = exp_flags_q.pop_front();
        if ({wall_right, wall_left, wall_bottom, wall_top} !== ef) begin
          n_fail++;
          $display("FAIL flags actual=%h required=%h", {wall_right, wall_left, wall_bottom, wall_top}, ef);
        end
        n_checks++;
        if (rel !== 4*N+2) begin
          n_fail++;
          $display("FAIL done_cycle actual=%0d required=%0d", rel, 4*N+2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_objs();
    for (int i = 0; i < N; i++) begin
      obj_x[i] = 10'(ox[i]);
      obj_y[i] = 10'(oy[i]);
      obj_s[i] = 10'(os[i]);
    end
  endtask

  // Launch a scan from cycle 0 and queue what the DUT must produce for it.
  task automatic start_scan();
    logic [4*N-1:0] fl;
    int px, py, a;
    bit f;
    set_objs();
    fl = '0;
    for (int i = 0; i < N; i++) begin
      for (int d = 0; d < 4; d++) begin
        px = ox[i];
        py = oy[i];
        case (d)
          0: py = oy[i] - os[i] - 1;
          1: py = oy[i] + os[i] + 1;
          2: px = ox[i] - os[i] - 1;
          default: px = ox[i] + os[i] + 1;
        endcase
        if (px < 0 || px >= 640 || py < 0 || py >= 480) begin
          a = 0;
          f = 1'b1;
        end else begin
          a = (py / 16) * 40 + px / 16;
          f = rom_bit(a);
        end
        exp_addr_q.push_back(a);
        exp_rel_q.push_back(4*i + d + 1);
        fl[d*N + i] = f;
      end
    end
    exp_flags_q.push_back(fl);
    start_cyc = cyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic base_objs();
    ox[0] = 100; oy[0] = 100; os[0] = 4;
    ox[1] = 300; oy[1] = 300; os[1] = 4;
    ox[2] = 500; oy[2] = 200; os[2] = 4;
    ox[3] = 200; oy[3] = 400; os[3] = 4;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (maze_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || maze_addr !== '0) begin
        n_fail++;
        $display("FAIL reset_idle rd=%b busy=%b done=%b addr=%0d required=0", maze_rd, busy, done, maze_addr);
      end
      n_checks++;
      if ({wall_top, wall_bottom, wall_left, wall_right} !== '0) begin
        n_fail++;
        $display("FAIL reset_flags actual=%h required=0", {wall_top, wall_bottom, wall_left, wall_right});
      end
    end
  endtask

  task automatic test_rom_wall();
    bit seen;
    rom_mode = 0;
    base_objs();
    start_scan();
    wait_done(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rom_wall_done actual=timeout required=done"); end
    n_checks++;
    if (wall_left !== 4'b0001 || wall_top !== 4'b0000 || wall_bottom !== 4'b0000 || wall_right !== 4'b0000) begin
      n_fail++;
      $display("FAIL rom_wall_flags left=%b top=%b bottom=%b right=%b required left=0001 others=0000",
               wall_left, wall_top, wall_bottom, wall_right);
    end
    repeat (3) tick();
  endtask

  task automatic test_left_edge();
    bit seen;
    rom_mode = 1;
    base_objs();
    ox[1] = 3; oy[1] = 200;
    start_scan();
    wait_done(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL left_edge_done actual=timeout required=done"); end
    n_checks++;
    if (wall_left !== 4'b0010 || {wall_top, wall_bottom, wall_right} !== 12'h000) begin
      n_fail++;
      $display("FAIL left_edge_flags left=%b top=%b bottom=%b right=%b required left=0010 others=0000",
               wall_left, wall_top, wall_bottom, wall_right);
    end
    repeat (3) tick();
  endtask

  task automatic test_bottom_edge();
    bit seen;
    rom_mode = 2;
    base_objs();
    ox[2] = 320; oy[2] = 476;
    start_scan();
    wait_done(seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bottom_edge_done actual=timeout required=done"); end
    n_checks++;
    if ({wall_bottom[2], wall_top[2], wall_left[2], wall_right[2]} !== 4'b1111) begin
      n_fail++;
      $display("FAIL bottom_edge_obj2 b/t/l/r actual=%b%b%b%b required=1111",
               wall_bottom[2], wall_top[2], wall_left[2], wall_right[2]);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    bit seen;
    int dc0;
    rom_mode = 2;
    base_objs();
    dc0 = done_count;
    start_scan();
    repeat (4) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(seen);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_at_done actual=%b required=1", busy); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after actual=%b required=0", busy); end
    repeat (25) tick();
    n_checks++;
    if (done_count !== dc0 + 1) begin
      n_fail++;
      $display("FAIL b2b_done_count actual=%0d required=%0d", done_count - dc0, 1);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    int dc0;
    rom_mode = 0;
    base_objs();
    start_scan();
    repeat (6) tick();
    Reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || maze_rd !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ctrl busy=%b rd=%b done=%b required=0", busy, maze_rd, done);
    end
    n_checks++;
    if ({wall_top, wall_bottom, wall_left, wall_right} !== '0) begin
      n_fail++;
      $display("FAIL midreset_flags actual=%h required=0", {wall_top, wall_bottom, wall_left, wall_right});
    end
    exp_addr_q.delete();
    exp_rel_q.delete();
    exp_flags_q.delete();
    Reset = 1'b0;
    dc0 = done_count;
    repeat (25) tick();
    n_checks++;
    if (done_count !== dc0) begin
      n_fail++;
      $display("FAIL midreset_no_done actual=%0d required=0", done_count - dc0);
    end
    start_scan();
    wait_done(seen);
    n_checks++;
    if (!seen || wall_left !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_fresh_scan seen=%b left=%b required seen=1 left=0001", seen, wall_left);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_rom_wall();
    test_left_edge();
    test_bottom_edge();
    test_back_to_back();
    test_reset_mid_scan();
    n_checks++;
    if (exp_addr_q.size() != 0 || exp_flags_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations addrs=%0d flags=%0d required=0", exp_addr_q.size(), exp_flags_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end
endmodule
